// File: rtl/bp_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
// Table entries hold a 2-bit saturating direction counter and a target.
package bp_pkg;

    // Widest PC the entry record can describe.
    localparam int MAX_XLEN = 64;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_XLEN-1:0] tag;
        logic [MAX_XLEN-1:0] target;
        ctr_t                ctr;
    } btb_entry_t;

    localparam ctr_t CTR_RESET    = SNT;
    localparam ctr_t ALLOC_BRANCH = WT;
    localparam ctr_t ALLOC_JUMP   = ST;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t ctr_in,
    input  logic taken,
    output ctr_t ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        unique case (ctr_in)
            SNT:     ctr_out = taken ? WNT : SNT;
            WNT:     ctr_out = taken ? WT  : SNT;
            WT:      ctr_out = taken ? ST  : WNT;
            ST:      ctr_out = taken ? ST  : WT;
            default: ctr_out = ctr_in;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor: combinational IF lookup, EX-side update
// and misprediction detection. Define BP_STATS_EN to build the event counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Only valid bits and counters are reset; tags and targets are gated by valid.
    logic [ENTRIES-1:0] valid_q;
    ctr_t               ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

    btb_entry_t rd_entry;
    logic       if_hit;
    logic       unused_rd_hi;

    assign rd_entry = '{valid:  valid_q[if_idx],
                        tag:    MAX_XLEN'(tag_q[if_idx]),
                        target: MAX_XLEN'(target_q[if_idx]),
                        ctr:    ctr_q[if_idx]};

    assign if_hit       = rd_entry.valid && (rd_entry.tag == MAX_XLEN'(if_tag));
    assign pred_taken   = if_hit && rd_entry.ctr[1];
    assign pred_target  = pred_taken ? rd_entry.target[XLEN-1:0] : if_pc + XLEN'(4);
    assign unused_rd_hi = ^(rd_entry.target >> XLEN);

    logic is_cf;
    logic ex_hit;
    ctr_t ctr_step;

    assign is_cf  = ex_is_branch | ex_is_jump;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_counter2 u_ctr (
        .ctr_in  (ctr_q[ex_idx]),
        .taken   (ex_taken),
        .ctr_out (ctr_step)
    );

    // A jal/jalr flag takes precedence if both type flags are raised.
    logic wr_en;
    logic wr_target;
    logic inval;
    ctr_t new_ctr;

    always_comb begin
        wr_en     = 1'b0;
        wr_target = 1'b0;
        inval     = 1'b0;
        new_ctr   = ctr_step;
        if (ex_valid) begin
            if (is_cf) begin
                if (ex_hit) begin
                    wr_en = 1'b1;
                    if (ex_is_jump) begin
                        new_ctr   = ALLOC_JUMP;
                        wr_target = 1'b1;
                    end else begin
                        wr_target = ex_taken;
                    end
                end else if (ex_taken) begin
                    wr_en     = 1'b1;
                    wr_target = 1'b1;
                    new_ctr   = ex_is_jump ? ALLOC_JUMP : ALLOC_BRANCH;
                end
            end else if (ex_pred_taken && ex_hit) begin
                inval = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= new_ctr;
        end else if (inval) begin
            valid_q[ex_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[ex_idx] <= ex_tag;
            if (wr_target) begin
                target_q[ex_idx] <= ex_target;
            end
        end
    end

    // A predicted-taken non-control-flow instruction came from a stale entry.
    logic dir_wrong;
    logic tgt_wrong;

    assign dir_wrong   = ex_taken != ex_pred_taken;
    assign tgt_wrong   = ex_taken && ex_pred_taken && (ex_target != ex_pred_target);
    assign mispredict  = ex_valid && ((is_cf && (dir_wrong || tgt_wrong)) ||
                                      (!is_cf && ex_pred_taken));
    assign redirect_pc = (is_cf && ex_taken) ? ex_target : ex_pc + XLEN'(4);

`ifdef BP_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (ex_valid && is_cf && (branches_q != '1)) begin
                branches_q <= branches_q + 32'd1;
            end
            if (mispredict && (mispredicts_q != '1)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the five-stage RISC-V pipeline. It replaces the resolve-in-EX, always-flush jump control with a direct-mapped branch target buffer holding 2-bit saturating counters. IF looks it up combinationally to choose the next PC. EX resolves each branch and jump, updates the table on the clock edge, and raises redirect/flush only on a misprediction.

## Interface
Parameters:
- XLEN, 32, PC and target width.
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = $clog2(ENTRIES).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  IF prediction: redirect fetch to pred_target.
- pred_target  out  XLEN  predicted next PC; if_pc+4 when not taken.
- ex_valid  in  1  EX holds a valid instruction this cycle; one cycle per instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  jal/jalr.
- ex_taken  in  1  resolved direction; 1 for jumps.
- ex_target  in  XLEN  resolved target.
- ex_pred_taken  in  1  pred_taken carried down the pipeline with the instruction.
- ex_pred_target  in  XLEN  pred_target carried down the pipeline with the instruction.
- mispredict  out  1  flush IF/ID and ID/EX this cycle.
- redirect_pc  out  XLEN  correct next PC when mispredict=1.
- stat_branches  out  32  resolved branch/jump count (see Configuration).
- stat_mispredicts  out  32  misprediction count.

## Operation
- Entry: valid, tag = PC[XLEN-1:IDX_W+2], target[XLEN-1:0], ctr[1:0]. Index = PC[IDX_W+1:2].
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4, with wrap mod 2^XLEN.
- Counter states: SNT=00, WNT=01, WT=10, ST=11. Increment on taken and decrement on not-taken, saturating at ST and SNT.
- Update, at the clock edge when ex_valid and (ex_is_branch | ex_is_jump):
  - Hit, branch: the counter steps; target is overwritten when taken.
  - Hit, jump: ctr=ST; target is overwritten.
  - Miss, taken: allocate the entry, overwriting any occupant. ctr = WT for a branch, ST for a jump; target = ex_target.
  - Miss, not taken: no write.
- mispredict (combinational) = ex_valid & one of:
  - (branch|jump) & ex_taken≠ex_pred_taken;
  - (branch|jump) & ex_taken & ex_pred_taken & ex_target≠ex_pred_target;
  - a non-branch, non-jump instruction with ex_pred_taken=1 (stale entry). In this case the entry at ex_pc's index is invalidated on the edge if its tag matches.
- redirect_pc = ex_taken ? ex_target : ex_pc+4, except for the stale case, which uses ex_pc+4.
- ex_valid=0: no update, mispredict=0, redirect_pc don't-care.

## Timing
- Lookup and mispredict/redirect have zero-cycle combinational latency. Table writes take effect at the next rising edge.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-before-write).
- rst asserted at any time, including mid-update: all valid bits and ctr clear to 0 immediately. Stats clear to 0. Targets and tags are don't-care.
- Outputs under reset: pred_taken=0, pred_target=if_pc+4, mispredict follows its inputs. The pipeline holds ex_valid=0 during reset.
- No stall input: the pipeline must present each instruction with ex_valid=1 for exactly one cycle.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on every ex_valid & (branch|jump).
  - stat_mispredicts increments on every mispredict.
  - Both saturate at 2^32-1.
- BP_STATS_EN undefined: no counter flops. Both stat ports are tied to 0; the ports remain so the top level is unchanged.

## Structure
- Package bp_pkg holds:
  - the ctr_t enum (SNT, WNT, WT, ST);
  - the btb_entry_t struct (valid, tag, target, ctr);
  - the CTR_RESET=SNT constant;
  - the ALLOC_BRANCH=WT and ALLOC_JUMP=ST constants.
- Sub-module sat_counter2 is the pure next-state function: ctr_t in, taken in, ctr_t out. It is instantiated once on the update path.

## Test plan
- After reset, if_pc=0x100 → pred_taken=0, pred_target=0x104. Stats read 0.
- Branch at 0x100, taken to 0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. The next lookup of 0x100 gives pred_taken=1, pred_target=0x80.
- Same branch resolved not-taken twice from WT → the first resolve gives mispredict=1, redirect 0x104, ctr WNT. The second gives mispredict=0, ctr SNT, and the lookup then predicts not taken.
- jal at 0x200 to 0x400 and jalr at 0x200+4·ENTRIES (same index) → the second evicts the first. A lookup of 0x200 then misses, predicting 0x204.
- ex_valid with a non-branch at 0x300 and ex_pred_taken=1 → mispredict=1, redirect_pc=0x304. The matching entry is invalidated.
- rst pulsed asynchronously between edges while an update is pending → the table clears immediately and no write occurs. With BP_STATS_EN, stats read 0.
